// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package servo_pkg;

  // Default timing for a 50 MHz clock: ~3.9 us tick, 1.0 ms minimum pulse, 20 ms frame.
  localparam int DEF_N_CH         = 4;
  localparam int DEF_DW           = 8;
  localparam int DEF_PRESC        = 195;
  localparam int DEF_MIN_TICKS    = 256;
  localparam int DEF_PERIOD_TICKS = 5120;
  localparam int DEF_RESET_POS    = 128;
  localparam int DEF_SLEW_STEP    = 4;

  // Counter width for a modulo-n counter; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PRESC_W = cnt_w(DEF_PRESC);
  localparam int DEF_FRAME_W = cnt_w(DEF_PERIOD_TICKS);

  typedef logic [DEF_DW-1:0] pos_t;

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: pending/target/active position, slew limiter, enable latch, pulse comparator.
// Latency: pwm_o is registered, one clk behind the shared frame counter.
// Backpressure: none; load and boundary strobes are always accepted.
// Ports: boundary_i/load_i/pend_i strobes from the top, pos_i requested position, en_i enable,
//        slew_en_i rate-limit select, frame_cnt_i shared tick counter, pwm_o servo pulse.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int FW        = DEF_FRAME_W,
  parameter int MIN_TICKS = DEF_MIN_TICKS,
  parameter int RESET_POS = DEF_RESET_POS,
  parameter int SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boundary_i,
  input  logic          load_i,
  input  logic          pend_i,
  input  logic [DW-1:0] pos_i,
  input  logic          en_i,
  input  logic          slew_en_i,
  input  logic [FW-1:0] frame_cnt_i,
  output logic          pwm_o
);

  localparam logic [DW-1:0] RST_POS = DW'(RESET_POS);
  localparam logic [DW-1:0] STEP    = DW'(SLEW_STEP);
  localparam logic [FW-1:0] MIN_W   = FW'(MIN_TICKS);

  logic [DW-1:0] pending_q, pending_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] active_q, active_d;
  logic          en_lat_q, en_lat_d;
  logic          pwm_q, pwm_d;
  logic [DW-1:0] tgt_new, diff, slewed;

  always_comb begin
    // pend_i is the pre-boundary flag, so a load landing on the boundary cycle
    // leaves the old pending value to be transferred here.
    tgt_new = pend_i ? pending_q : target_q;

    // Move at most STEP toward the target; clamp to the target so it never overshoots
    // and, since active+STEP only happens while target is further away, never wraps.
    if (tgt_new >= active_q) begin
      diff   = tgt_new - active_q;
      slewed = (diff > STEP) ? active_q + STEP : tgt_new;
    end else begin
      diff   = active_q - tgt_new;
      slewed = (diff > STEP) ? active_q - STEP : tgt_new;
    end

    pending_d = load_i ? pos_i : pending_q;
    target_d  = target_q;
    active_d  = active_q;
    en_lat_d  = en_lat_q;
    if (boundary_i) begin
      target_d = tgt_new;
      active_d = slew_en_i ? slewed : tgt_new;
      en_lat_d = en_i;
    end

    // Threshold fits in FW bits because PERIOD_TICKS exceeds MIN_TICKS + 2**DW - 1.
    pwm_d = en_lat_q && (frame_cnt_i < (MIN_W + FW'(active_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= RST_POS;
      target_q  <= RST_POS;
      active_q  <= RST_POS;
      en_lat_q  <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
      active_q  <= active_d;
      en_lat_q  <= en_lat_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM: shared prescaler and frame counter, frame-synchronous position updates.
// Latency: pwm_o rises one clk after frame_o; loads take effect at the next frame boundary.
// Backpressure: none; load_i is always accepted, later loads in a frame overwrite earlier ones.
// Ports: clk, rst_n (async active-low); pos_i packed positions (ch k at [k*DW +: DW]); load_i
//        capture strobe; en_i per-channel enable; slew_en rate-limit select; pwm_o pulses;
//        frame_o one-cycle frame start; pend_o update waiting for the next boundary.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int DW           = DEF_DW,
  parameter int PRESC        = DEF_PRESC,
  parameter int MIN_TICKS    = DEF_MIN_TICKS,
  parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int RESET_POS    = DEF_RESET_POS,
  parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*DW-1:0] pos_i,
  input  logic               load_i,
  input  logic [N_CH-1:0]    en_i,
  input  logic               slew_en,
  output logic [N_CH-1:0]    pwm_o,
  output logic               frame_o,
  output logic               pend_o
);

  localparam int PW = cnt_w(PRESC);
  localparam int FW = cnt_w(PERIOD_TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          frame_o_q, frame_o_d;
  logic          pend_q, pend_d;
  logic          tick, boundary;

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (frame_q == FRAME_LAST);

    presc_d = tick ? '0 : presc_q + 1'b1;
    frame_d = frame_q;
    if (tick) begin
      frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
    end

    frame_o_d = boundary;

    // A load on the boundary cycle wins over the clear: its value waits for the next frame.
    pend_d = pend_q;
    if (boundary) pend_d = 1'b0;
    if (load_i)   pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      frame_q   <= '0;
      frame_o_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      frame_q   <= frame_d;
      frame_o_q <= frame_o_d;
      pend_q    <= pend_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    servo_pwm_channel #(
      .DW        (DW),
      .FW        (FW),
      .MIN_TICKS (MIN_TICKS),
      .RESET_POS (RESET_POS),
      .SLEW_STEP (SLEW_STEP)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .boundary_i  (boundary),
      .load_i      (load_i),
      .pend_i      (pend_q),
      .pos_i       (pos_i[k*DW +: DW]),
      .en_i        (en_i[k]),
      .slew_en_i   (slew_en),
      .frame_cnt_i (frame_q),
      .pwm_o       (pwm_o[k])
    );
  end

  assign frame_o = frame_o_q;
  assign pend_o  = pend_q;

endmodule
